// File: rtl/seq_generator.sv
// seq_generator: MSB-first one-hot (out1/out0) bit-stream source with per-bit tick
// pacing, optional frame looping and level-sensitive abort.
module seq_generator #(
    parameter int TICK_DIV = 49_000_000,
    parameter int MAX_LEN  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
    input  logic               loop,
    input  logic               abort,
    output logic               out1,
    output logic               out0,
    output logic               busy,
    output logic               done
);
    localparam int CW = TICK_DIV > 0 ? $clog2(TICK_DIV + 1) : 1;
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      last_q;
    logic [MAX_LEN-1:0] pat_q;
    logic               loop_q;
    logic [3:0]         len_eff;
    logic               tick;
    logic               accept;
    assign len_eff = (int'(len) > MAX_LEN) ? 4'(MAX_LEN) : len;
    assign accept  = start && len != 4'd0 && !abort;
    assign tick    = state == SEND && cnt == CW'(TICK_DIV);
    assign busy    = state == SEND;
    assign done    = state == DONE;
    assign out1    = busy && pat_q[idx];
    assign out0    = busy && !pat_q[idx];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            last_q <= '0;
            pat_q  <= '0;
            loop_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state  <= SEND;
                    cnt    <= '0;
                    pat_q  <= pattern;
                    loop_q <= loop;
                    last_q <= IW'(len_eff - 4'd1);
                    idx    <= IW'(len_eff - 4'd1);
                end
                SEND: if (abort) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (tick) begin
                    cnt <= '0;
                    if (idx != '0) idx <= idx - 1'b1;
                    else if (loop_q) idx <= last_q;
                    else state <= DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
